// File: rtl/clock_gate_ctrl.sv
// Idle-detect controller producing the registered enable for a unit-level clock gater.
// Optional gated-cycle statistics counter enabled by defining CGC_STATS_EN.
module clock_gate_ctrl #(
  parameter int IDLE_CYCLES = 16,
  parameter int WAKE_CYCLES = 2,
  parameter int CNT_W       = 8,
  parameter int STAT_W      = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              Busy,
  input  logic              ReqValid,
  output logic              ReqReady,
  input  logic              ForceOn,
  output logic              E,
  output logic              Gated,
  output logic [STAT_W-1:0] GatedCycles
);

  localparam longint MAX_CNT = (64'sd1 <<< CNT_W) - 64'sd1;

  if (IDLE_CYCLES < 1 || longint'(IDLE_CYCLES) > MAX_CNT) begin : g_bad_idle
    $error("clock_gate_ctrl: IDLE_CYCLES out of range 1..2^CNT_W-1");
  end
  if (WAKE_CYCLES < 0 || longint'(WAKE_CYCLES) > MAX_CNT) begin : g_bad_wake
    $error("clock_gate_ctrl: WAKE_CYCLES out of range 0..2^CNT_W-1");
  end

  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'((WAKE_CYCLES > 0) ? WAKE_CYCLES - 1 : 0);

  typedef enum logic [1:0] {RUN, GATED, WAKE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             e_d, gated_d;
  logic             idle, wake;

  assign idle     = ~Busy & ~ReqValid & ~ForceOn;
  assign wake     = Busy | ReqValid | ForceOn;
  assign ReqReady = (state_q == RUN);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RUN;
      cnt_q   <= '0;
      E       <= 1'b1;
      Gated   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      E       <= e_d;
      Gated   <= gated_d;
    end
  end

  // One counter serves both the idle run length (RUN) and the settle window (WAKE).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    e_d     = E;
    gated_d = Gated;
    case (state_q)
      RUN: begin
        e_d     = 1'b1;
        gated_d = 1'b0;
        if (!idle) begin
          cnt_d = '0;
        end else if (cnt_q == IDLE_LAST) begin
          state_d = GATED;
          e_d     = 1'b0;
          gated_d = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      GATED: begin
        e_d     = 1'b0;
        gated_d = 1'b1;
        if (wake) begin
          state_d = (WAKE_CYCLES == 0) ? RUN : WAKE;
          e_d     = 1'b1;
          gated_d = 1'b0;
          cnt_d   = '0;
        end
      end
      WAKE: begin
        e_d     = 1'b1;
        gated_d = 1'b0;
        if (cnt_q == WAKE_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
        e_d     = 1'b1;
        gated_d = 1'b0;
      end
    endcase
  end

`ifdef CGC_STATS_EN
  logic [STAT_W-1:0] stat_q;

  // Saturating count of cycles with the gater enable low; only reset clears it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_q <= '0;
    end else if (!E && (stat_q != {STAT_W{1'b1}})) begin
      stat_q <= stat_q + 1'b1;
    end
  end

  assign GatedCycles = stat_q;
`else
  assign GatedCycles = '0;
`endif

endmodule
